// File: rtl/input_word_port_pkg.sv
// Shared definitions for the operator input word port and its address decode.
package input_word_port_pkg;

  typedef enum logic [1:0] {
    REL,
    PRESS_WAIT,
    PRESSED,
    REL_WAIT
  } db_state_t;

  localparam int unsigned SW_WIDTH_DEF   = 8;
  localparam int unsigned WORD_WIDTH_DEF = 32;
  localparam int unsigned BYTES_PER_WORD = WORD_WIDTH_DEF / SW_WIDTH_DEF;

  // Memory-mapped address the RAM decoder steers to this port's read path.
  localparam logic [15:0] IN_PORT_ADDR = 16'hFFFC;

endpackage

// File: rtl/input_word_port_btn_debounce.sv
// Push-button synchronizer and debouncer: one-cycle pulse per accepted press,
// plus the debounced level.
module btn_debounce
  import input_word_port_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press_pulse,
  output logic level
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          btn_s;
  db_state_t     state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      btn_s <= sync1;
    end
  end

  // The transition fires on the cycle the counter steps onto DEBOUNCE_CYCLES,
  // giving 2 sync cycles + DEBOUNCE_CYCLES from raw edge to pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= REL;
      cnt         <= '0;
      press_pulse <= 1'b0;
      level       <= 1'b0;
    end else begin
      press_pulse <= 1'b0;
      case (state)
        REL: begin
          if (btn_s) begin
            state <= PRESS_WAIT;
            cnt   <= CW'(1);
          end
        end
        PRESS_WAIT: begin
          if (!btn_s) begin
            state <= REL;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state       <= PRESSED;
            cnt         <= cnt + 1'b1;
            press_pulse <= 1'b1;
            level       <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!btn_s) begin
            state <= REL_WAIT;
            cnt   <= CW'(1);
          end
        end
        REL_WAIT: begin
          if (btn_s) begin
            state <= PRESSED;
          end else if (cnt == LAST) begin
            state <= REL;
            cnt   <= '0;
            level <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= REL;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/input_word_port.sv
// Operator input port: assembles four debounced switch bytes into a word and
// presents it to the CPU read path with a valid / read-to-clear handshake.
module input_word_port
  import input_word_port_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned SW_WIDTH        = 8,
  parameter int unsigned WORD_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  btn_raw,
  input  logic [SW_WIDTH-1:0]   sw,
  input  logic                  rd_en,
  output logic [WORD_WIDTH-1:0] rd_data,
  output logic                  data_valid,
  output logic                  overrun,
  output logic [1:0]            byte_cnt
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic                           press_pulse;
  logic                           level;
  logic                           press;
  logic                           complete;
  logic [WORD_WIDTH-SW_WIDTH-1:0] partial;
  logic [WORD_WIDTH-1:0]          word;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .press_pulse(press_pulse),
    .level      (level)
  );

  // level is always high while the pulse is; qualifying costs nothing.
  assign press    = press_pulse & level;
  assign complete = press && (byte_cnt == LAST_BYTE);

  // Only the lower bytes of the shift register are kept: the top byte would
  // be shifted straight out into rd_data at completion, so word is formed
  // combinationally from the held bytes plus the current switches.
  assign word = {partial, sw};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      partial    <= '0;
      byte_cnt   <= '0;
      rd_data    <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (press) begin
        partial  <= word[WORD_WIDTH-SW_WIDTH-1:0];
        byte_cnt <= byte_cnt + 1'b1;
      end

      if (complete && (!data_valid || rd_en)) begin
        rd_data <= word;
      end

      if (complete) begin
        data_valid <= 1'b1;
      end else if (rd_en) begin
        data_valid <= 1'b0;
      end

      if (complete && data_valid && !rd_en) begin
        overrun <= 1'b1;
      end else if (rd_en) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_input_word_port.sv
// Self-checking bench for input_word_port with a short debounce window.
module tb_input_word_port;

  localparam int unsigned DB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_raw = 1'b0;
  logic [7:0]  sw = '0;
  logic        rd_en = 1'b0;
  logic [31:0] rd_data;
  logic        data_valid;
  logic        overrun;
  logic [1:0]  byte_cnt;

  int vectors = 0;
  int miscompares = 0;

  input_word_port #(
    .DEBOUNCE_CYCLES(DB),
    .SW_WIDTH       (8),
    .WORD_WIDTH     (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_raw),
    .sw        (sw),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .data_valid(data_valid),
    .overrun   (overrun),
    .byte_cnt  (byte_cnt)
  );

  always #5 clk = ~clk;

  typedef enum int {OP_PRESS, OP_READ, OP_PRESS_RD} op_t;

  typedef struct {
    op_t         op;
    logic [7:0]  swv;
    logic [31:0] data;
    logic        valid;
    logic        ovr;
    logic [1:0]  cnt;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model state: bytes gathered so far and the presented word.
  logic [7:0]  m_bytes[$];
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ovr;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] d, input logic v,
                         input logic o, input logic [1:0] c);
    chk({tag, ".rd_data"}, rd_data, d);
    chk({tag, ".data_valid"}, {31'd0, data_valid}, {31'd0, v});
    chk({tag, ".overrun"}, {31'd0, overrun}, {31'd0, o});
    chk({tag, ".byte_cnt"}, {30'd0, byte_cnt}, {30'd0, c});
  endtask

  // Clean press held 10 cycles then released 10 cycles; optional rd_en
  // aligned with the cycle in which the press is accepted.
  task automatic do_press(input logic [7:0] v, input bit rd_at_pulse);
    sw = v;
    btn_raw = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (rd_at_pulse && k == 2 + DB) rd_en = 1'b1;
      if (k == 3 + DB) rd_en = 1'b0;
    end
    btn_raw = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic do_read();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  function automatic vec_t mk(op_t op, logic [7:0] s, logic [31:0] d, logic v,
                              logic o, logic [1:0] c);
    vec_t r;
    r.op = op; r.swv = s; r.data = d; r.valid = v; r.ovr = o; r.cnt = c;
    return r;
  endfunction

  function automatic void model_press(input logic [7:0] v);
    logic [31:0] w;
    m_bytes.push_back(v);
    if (m_bytes.size() == 4) begin
      w = (32'(m_bytes[0]) << 24) | (32'(m_bytes[1]) << 16) |
          (32'(m_bytes[2]) << 8)  |  32'(m_bytes[3]);
      m_bytes.delete();
      if (m_valid) m_ovr = 1'b1;
      else begin
        m_data  = w;
        m_valid = 1'b1;
      end
    end
  endfunction

  function automatic void model_read();
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endfunction

  initial begin
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_all("reset", 32'h0, 1'b0, 1'b0, 2'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean press: pulse after 2 + DB cycles, byte_cnt one cycle later.
    sw = 8'h12;
    btn_raw = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1 + DB) chk("latency.pulse_early", {31'd0, dut.u_db.press_pulse}, 32'd0);
      if (k == 2 + DB) chk("latency.pulse", {31'd0, dut.u_db.press_pulse}, 32'd1);
      if (k == 2 + DB) chk("latency.cnt_before", {30'd0, byte_cnt}, 32'd0);
      if (k == 3 + DB) chk("latency.cnt_after", {30'd0, byte_cnt}, 32'd1);
    end
    btn_raw = 1'b0;
    repeat (10) @(negedge clk);

    // Bounce: short highs never satisfy the debounce window.
    for (int k = 0; k < 20; k++) begin
      if (k % 2 == 0) btn_raw = ~btn_raw;
      @(negedge clk);
    end
    btn_raw = 1'b0;
    repeat (10) @(negedge clk);
    chk_all("bounce", 32'h0, 1'b0, 1'b0, 2'd1);

    tbl.push_back(mk(OP_PRESS,    8'h34, 32'h0,        1'b0, 1'b0, 2'd2));
    tbl.push_back(mk(OP_PRESS,    8'h56, 32'h0,        1'b0, 1'b0, 2'd3));
    tbl.push_back(mk(OP_PRESS,    8'h78, 32'h12345678, 1'b1, 1'b0, 2'd0));
    tbl.push_back(mk(OP_PRESS,    8'hAA, 32'h12345678, 1'b1, 1'b0, 2'd1));
    tbl.push_back(mk(OP_PRESS,    8'hBB, 32'h12345678, 1'b1, 1'b0, 2'd2));
    tbl.push_back(mk(OP_PRESS,    8'hCC, 32'h12345678, 1'b1, 1'b0, 2'd3));
    tbl.push_back(mk(OP_PRESS,    8'hDD, 32'h12345678, 1'b1, 1'b1, 2'd0));
    tbl.push_back(mk(OP_READ,     8'h00, 32'h12345678, 1'b0, 1'b0, 2'd0));
    tbl.push_back(mk(OP_READ,     8'h00, 32'h12345678, 1'b0, 1'b0, 2'd0));
    tbl.push_back(mk(OP_PRESS,    8'h0A, 32'h12345678, 1'b0, 1'b0, 2'd1));
    tbl.push_back(mk(OP_PRESS,    8'h0B, 32'h12345678, 1'b0, 1'b0, 2'd2));
    tbl.push_back(mk(OP_PRESS,    8'h0C, 32'h12345678, 1'b0, 1'b0, 2'd3));
    tbl.push_back(mk(OP_PRESS,    8'h0D, 32'h0A0B0C0D, 1'b1, 1'b0, 2'd0));
    tbl.push_back(mk(OP_PRESS,    8'h01, 32'h0A0B0C0D, 1'b1, 1'b0, 2'd1));
    tbl.push_back(mk(OP_PRESS,    8'h02, 32'h0A0B0C0D, 1'b1, 1'b0, 2'd2));
    tbl.push_back(mk(OP_PRESS,    8'h03, 32'h0A0B0C0D, 1'b1, 1'b0, 2'd3));
    tbl.push_back(mk(OP_PRESS_RD, 8'h04, 32'h01020304, 1'b1, 1'b0, 2'd0));

    for (int i = 0; i < tbl.size(); i++) begin
      case (tbl[i].op)
        OP_READ:     do_read();
        OP_PRESS_RD: do_press(tbl[i].swv, 1'b1);
        default:     do_press(tbl[i].swv, 1'b0);
      endcase
      chk_all($sformatf("tbl%0d", i), tbl[i].data, tbl[i].valid, tbl[i].ovr, tbl[i].cnt);
    end

    // Asynchronous reset mid-assembly, then a fresh word.
    do_press(8'h55, 1'b0);
    do_press(8'h66, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_all("async_reset", 32'h0, 1'b0, 1'b0, 2'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) do_press(8'hFF, 1'b0);
    chk_all("after_reset", 32'hFFFFFFFF, 1'b1, 1'b0, 2'd0);

    // Randomized presses and reads against the behavioural model.
    m_bytes.delete();
    m_data  = 32'hFFFFFFFF;
    m_valid = 1'b1;
    m_ovr   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        do_press(v, 1'b0);
        model_press(v);
      end else begin
        do_read();
        model_read();
      end
      chk_all($sformatf("rand%0d", i), m_data, m_valid, m_ovr, 2'(m_bytes.size()));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
